core_completion_monitor: RTL and testbench

CORE_COMPLETION_MONITOR -- requirements
Module: core_completion_monitor

---
 rtl/completion_monitor_pkg.sv | 20 ++
 rtl/completion_core_fsm.sv | 100 ++++++++++
 rtl/core_completion_monitor.sv | 117 +++++++++++
 tb/tb_core_completion_monitor.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/completion_monitor_pkg.sv
// Shared definitions for the core completion monitor: per-core FSM state
// encoding and default parameter values.
// Optional feature macro: COMPLETION_MONITOR_TIMEOUT_EN (see top module).
package completion_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } core_state_t;

  localparam int DEF_NUM_CORES        = 2;
  localparam int DEF_ADDRESS_BITS     = 32;
  localparam int DEF_DATA_WIDTH       = 32;
  localparam int DEF_DRAIN_CYCLES     = 50;
  localparam int DEF_CYCLE_COUNT_BITS = 32;
  localparam int DEF_TIMEOUT_CYCLES   = 100000;

endpackage

// File: rtl/completion_core_fsm.sv
// Per-core completion tracker: waits for the core PC to reach its end address,
// lets the pipeline drain, then latches the pass/fail verdict.
//
// state | meaning
// IDLE  | no run started since reset
// RUN   | run active, watching for PC == end_address
// DRAIN | end PC seen, counting down drain cycles
// DONE  | verdict latched, held until the next start
//
// done_nxt/pass_nxt expose the next-cycle flag values so the top can register
// its reductions in the same cycle the per-core flags change.
module completion_core_fsm
  import completion_monitor_pkg::*;
#(
  parameter int ADDRESS_BITS     = DEF_ADDRESS_BITS,
  parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int DRAIN_CYCLES     = DEF_DRAIN_CYCLES,
  parameter int CYCLE_COUNT_BITS = DEF_CYCLE_COUNT_BITS
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort,
  input  logic [CYCLE_COUNT_BITS-1:0] cycle_count,
  input  logic [ADDRESS_BITS-1:0]     pc,
  input  logic [ADDRESS_BITS-1:0]     end_address,
  input  logic [DATA_WIDTH-1:0]       check_value,
  input  logic [DATA_WIDTH-1:0]       expected_value,
  output logic                        done,
  output logic                        pass,
  output logic [CYCLE_COUNT_BITS-1:0] cycles,
  output logic                        done_nxt,
  output logic                        pass_nxt
);

  localparam int DRAIN_BITS = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [DRAIN_BITS-1:0] DRAIN_LOAD = DRAIN_BITS'(DRAIN_CYCLES);

  core_state_t           state;
  logic [DRAIN_BITS-1:0] drain;
  logic                  finishing;

  // Decide whether this core completes this cycle and what its flags become;
  // a timeout abort forces a fail verdict.
  always_comb begin
    finishing = 1'b0;
    case (state)
      RUN:     finishing = abort;
      DRAIN:   finishing = abort || (drain == '0);
      default: finishing = 1'b0;
    endcase
    if (start) begin
      done_nxt = 1'b0;
      pass_nxt = 1'b0;
    end else if (finishing) begin
      done_nxt = 1'b1;
      pass_nxt = !abort && (check_value == expected_value);
    end else begin
      done_nxt = done;
      pass_nxt = pass;
    end
  end

  // State, drain counter and registered per-core outputs; start beats everything.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      drain  <= '0;
      cycles <= '0;
      done   <= 1'b0;
      pass   <= 1'b0;
    end else if (start) begin
      state  <= RUN;
      drain  <= '0;
      cycles <= '0;
      done   <= 1'b0;
      pass   <= 1'b0;
    end else begin
      done <= done_nxt;
      pass <= pass_nxt;
      case (state)
        RUN: begin
          if (abort) begin
            state <= DONE;
          end else if (pc == end_address) begin
            cycles <= cycle_count;
            drain  <= DRAIN_LOAD;
            state  <= DRAIN;
          end
        end
        DRAIN: begin
          if (finishing) state <= DONE;
          else           drain <= drain - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/core_completion_monitor.sv
// Multi-core completion monitor: one completion_core_fsm per core plus a
// shared saturating cycle counter and registered summary flags.
// Optional macro COMPLETION_MONITOR_TIMEOUT_EN adds TIMEOUT_CYCLES and a
// timeout output that force-fails cores still running when the counter hits it.
module core_completion_monitor
  import completion_monitor_pkg::*;
#(
  parameter int NUM_CORES        = DEF_NUM_CORES,
  parameter int ADDRESS_BITS     = DEF_ADDRESS_BITS,
  parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int DRAIN_CYCLES     = DEF_DRAIN_CYCLES,
  parameter int CYCLE_COUNT_BITS = DEF_CYCLE_COUNT_BITS
`ifdef COMPLETION_MONITOR_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES
`endif
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [NUM_CORES*ADDRESS_BITS-1:0]     PC,
  input  logic [NUM_CORES*ADDRESS_BITS-1:0]     end_address,
  input  logic [NUM_CORES*DATA_WIDTH-1:0]       check_value,
  input  logic [NUM_CORES*DATA_WIDTH-1:0]       expected_value,
  output logic [NUM_CORES-1:0]                  core_done,
  output logic [NUM_CORES-1:0]                  core_pass,
  output logic [NUM_CORES*CYCLE_COUNT_BITS-1:0] core_cycles,
  output logic [$clog2(NUM_CORES+1)-1:0]        finish_count,
  output logic                                  all_done,
  output logic                                  all_pass
`ifdef COMPLETION_MONITOR_TIMEOUT_EN
  ,
  output logic                                  timeout
`endif
);

  localparam int FW = $clog2(NUM_CORES + 1);

  logic [CYCLE_COUNT_BITS-1:0] cycle_count;
  logic                        running;
  logic [NUM_CORES-1:0]        abort;
  logic [NUM_CORES-1:0]        done_nxt;
  logic [NUM_CORES-1:0]        pass_nxt;
  logic [FW-1:0]               done_count;

  // Global run-time counter: cleared by start, saturates instead of wrapping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_count <= '0;
      running     <= 1'b0;
    end else if (start) begin
      cycle_count <= '0;
      running     <= 1'b1;
    end else if (running && (cycle_count != '1)) begin
      cycle_count <= cycle_count + 1'b1;
    end
  end

`ifdef COMPLETION_MONITOR_TIMEOUT_EN
  logic timeout_hit;
  assign timeout_hit = running && (cycle_count == CYCLE_COUNT_BITS'(TIMEOUT_CYCLES));
  assign abort       = {NUM_CORES{timeout_hit}};

  // Sticky timeout flag, cleared only by start or reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)           timeout <= 1'b0;
    else if (start)       timeout <= 1'b0;
    else if (timeout_hit) timeout <= 1'b1;
  end
`else
  assign abort = '0;
`endif

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    completion_core_fsm #(
      .ADDRESS_BITS     (ADDRESS_BITS),
      .DATA_WIDTH       (DATA_WIDTH),
      .DRAIN_CYCLES     (DRAIN_CYCLES),
      .CYCLE_COUNT_BITS (CYCLE_COUNT_BITS)
    ) u_fsm (
      .clock          (clock),
      .reset          (reset),
      .start          (start),
      .abort          (abort[i]),
      .cycle_count    (cycle_count),
      .pc             (PC[i*ADDRESS_BITS +: ADDRESS_BITS]),
      .end_address    (end_address[i*ADDRESS_BITS +: ADDRESS_BITS]),
      .check_value    (check_value[i*DATA_WIDTH +: DATA_WIDTH]),
      .expected_value (expected_value[i*DATA_WIDTH +: DATA_WIDTH]),
      .done           (core_done[i]),
      .pass           (core_pass[i]),
      .cycles         (core_cycles[i*CYCLE_COUNT_BITS +: CYCLE_COUNT_BITS]),
      .done_nxt       (done_nxt[i]),
      .pass_nxt       (pass_nxt[i])
    );
  end

  // Population count of the next-cycle done flags.
  always_comb begin
    done_count = '0;
    for (int i = 0; i < NUM_CORES; i++) done_count = done_count + FW'(done_nxt[i]);
  end

  // Summary flags registered from next-state values so they track core_done exactly.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      finish_count <= '0;
      all_done     <= 1'b0;
      all_pass     <= 1'b0;
    end else begin
      finish_count <= done_count;
      all_done     <= &done_nxt;
      all_pass     <= (&done_nxt) && (&pass_nxt);
    end
  end

endmodule

// File: tb/tb_core_completion_monitor.sv
// Directed bench for core_completion_monitor (NUM_CORES=2, DRAIN_CYCLES=50).
// Inputs change #1 after a rising edge; outputs are checked at that same point.
module tb_core_completion_monitor;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] pc;
  logic [63:0] end_address;
  logic [63:0] check_value;
  logic [63:0] expected_value;
  logic [1:0]  core_done;
  logic [1:0]  core_pass;
  logic [63:0] core_cycles;
  logic [1:0]  finish_count;
  logic        all_done;
  logic        all_pass;
`ifdef COMPLETION_MONITOR_TIMEOUT_EN
  logic        timeout;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  core_completion_monitor #(
    .NUM_CORES        (2),
    .ADDRESS_BITS     (32),
    .DATA_WIDTH       (32),
    .DRAIN_CYCLES     (50),
    .CYCLE_COUNT_BITS (32)
`ifdef COMPLETION_MONITOR_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES   (1000)
`endif
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .PC             (pc),
    .end_address    (end_address),
    .check_value    (check_value),
    .expected_value (expected_value),
    .core_done      (core_done),
    .core_pass      (core_pass),
    .core_cycles    (core_cycles),
    .finish_count   (finish_count),
    .all_done       (all_done),
    .all_pass       (all_pass)
`ifdef COMPLETION_MONITOR_TIMEOUT_EN
    ,
    .timeout        (timeout)
`endif
  );

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    reset          = 1'b0;
    start          = 1'b0;
    pc             = '0;
    end_address    = {32'h168, 32'hB0};
    check_value    = '0;
    expected_value = '0;
    step(3);
    check("reset_done",   64'(core_done),    64'd0);
    check("reset_cycles", core_cycles,       64'd0);
    check("reset_count",  64'(finish_count), 64'd0);
    check("reset_all",    64'({all_done, all_pass}), 64'd0);
    reset = 1'b1;

    // match while IDLE must be ignored
    pc = {32'h168, 32'hB0};
    step(60);
    check("idle_ignore_done",   64'(core_done), 64'd0);
    check("idle_ignore_cycles", core_cycles,    64'd0);
    pc = '0;

    // run 1: start -> counter 0; core0 matches at counter 200
    pulse_start();
    step(200);
    pc[31:0] = 32'hB0;
    step(1);
    pc[31:0] = '0;
    check("c0_cycles", core_cycles[31:0], 64'd200);
    step(50);
    check("c0_done_early", 64'(core_done), 64'd0);
    step(1);
    check("c0_done",  64'(core_done),    64'b01);
    check("c0_pass",  64'(core_pass),    64'b01);
    check("c0_count", 64'(finish_count), 64'd1);
    check("c0_all",   64'({all_done, all_pass}), 64'd0);

    // counter is 252 here; core1 matches at 300 with a bad value, PC held
    // through drain, core0 (DONE) sees its end PC again
    step(48);
    check_value[63:32] = 32'h5;
    pc = {32'h168, 32'hB0};
    step(1);
    check("c1_cycles", core_cycles[63:32], 64'd300);
    step(50);
    check("c1_done_early", 64'(core_done), 64'b01);
    step(1);
    pc = '0;
    check("c1_done",       64'(core_done),    64'b11);
    check("c1_pass",       64'(core_pass),    64'b01);
    check("c1_count",      64'(finish_count), 64'd2);
    check("c1_all_done",   64'(all_done),     64'd1);
    check("c1_all_pass",   64'(all_pass),     64'd0);
    check("done_ignore",   core_cycles,       {32'd300, 32'd200});

    // restart while DONE, both cores match together at counter 30
    check_value = '0;
    pulse_start();
    check("restart_done",   64'(core_done),    64'd0);
    check("restart_pass",   64'(core_pass),    64'd0);
    check("restart_cycles", core_cycles,       64'd0);
    check("restart_count",  64'(finish_count), 64'd0);
    step(30);
    pc = {32'h168, 32'hB0};
    step(1);
    pc = '0;
    step(50);
    check("both_count_early", 64'(finish_count), 64'd0);
    step(1);
    check("both_count",  64'(finish_count), 64'd2);
    check("both_all",    64'({all_done, all_pass}), 64'b11);
    check("both_cycles", core_cycles, {32'd30, 32'd30});

    // reset during drain aborts the run
    pulse_start();
    step(10);
    pc[31:0] = 32'hB0;
    step(1);
    pc[31:0] = '0;
    step(5);
    check("pre_reset_cycles", core_cycles, {32'd0, 32'd10});
    reset = 1'b0;
    #2;
    check("async_reset_cycles", core_cycles, 64'd0);
    check("async_reset_flags",
          64'({core_done, core_pass, finish_count, all_done, all_pass}), 64'd0);
    step(1);
    reset = 1'b1;
    pc = {32'h168, 32'hB0};
    step(70);
    check("post_reset_done",   64'(core_done), 64'd0);
    check("post_reset_cycles", core_cycles,    64'd0);
    pc = '0;

`ifdef COMPLETION_MONITOR_TIMEOUT_EN
    // core0 finishes normally at counter 5, core1 never matches
    pulse_start();
    step(5);
    pc[31:0] = 32'hB0;
    step(1);
    pc[31:0] = '0;
    step(994);
    check("to_before_done", 64'(core_done), 64'b01);
    check("to_before_flag", 64'(timeout),   64'd0);
    step(1);
    check("to_done",     64'(core_done), 64'b11);
    check("to_pass",     64'(core_pass), 64'b01);
    check("to_flag",     64'(timeout),   64'd1);
    check("to_all_pass", 64'(all_pass),  64'd0);
    step(5);
    check("to_sticky",   64'(timeout),   64'd1);
    pulse_start();
    check("to_cleared",  64'(timeout),   64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
